// File: rtl/pll_reset_sequencer.sv
// Qualifies the PLL lock flag and releases core then audio resets in order;
// any lock loss after core release reasserts both and is recorded in sticky diagnostics.
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             clear_flags,
    output logic             core_reset,
    output logic             audio_reset,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [STAB_W-1:0] w_stab_cnt_nxt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic              r_core_reset;
    logic              w_core_reset_nxt;
    logic              r_audio_reset;
    logic              w_audio_reset_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic              r_lock_lost;
    logic              w_lock_lost_nxt;
    logic [CNT_W-1:0]  r_loss_count;
    logic [CNT_W-1:0]  w_loss_count_nxt;
    logic              w_loss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    // Lock is only "lost" once the core has been let out of reset.
    assign w_loss = ~r_sync2 & ((r_state == RELEASE) || (r_state == RUN));

    always_comb begin
        w_state_nxt       = r_state;
        w_stab_cnt_nxt    = r_stab_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_core_reset_nxt  = r_core_reset;
        w_audio_reset_nxt = r_audio_reset;
        w_ready_nxt       = r_ready;
        case (r_state)
            WAIT_LOCK: begin
                w_core_reset_nxt  = 1'b1;
                w_audio_reset_nxt = 1'b1;
                w_ready_nxt       = 1'b0;
                if (r_sync2) begin
                    w_state_nxt    = STABILIZE;
                    w_stab_cnt_nxt = STAB_W'(1);
                end
            end
            STABILIZE: begin
                if (!r_sync2) begin
                    w_state_nxt    = WAIT_LOCK;
                    w_stab_cnt_nxt = '0;
                end else begin
                    w_stab_cnt_nxt = r_stab_cnt + 1'b1;
                    if (r_stab_cnt == STAB_LAST) begin
                        w_state_nxt      = RELEASE;
                        w_core_reset_nxt = 1'b0;
                        w_gap_cnt_nxt    = '0;
                    end
                end
            end
            RELEASE: begin
                if (!r_sync2) begin
                    w_state_nxt       = WAIT_LOCK;
                    w_core_reset_nxt  = 1'b1;
                    w_audio_reset_nxt = 1'b1;
                    w_ready_nxt       = 1'b0;
                    w_stab_cnt_nxt    = '0;
                    w_gap_cnt_nxt     = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_nxt       = RUN;
                        w_audio_reset_nxt = 1'b0;
                        w_ready_nxt       = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!r_sync2) begin
                    w_state_nxt       = WAIT_LOCK;
                    w_core_reset_nxt  = 1'b1;
                    w_audio_reset_nxt = 1'b1;
                    w_ready_nxt       = 1'b0;
                    w_stab_cnt_nxt    = '0;
                    w_gap_cnt_nxt     = '0;
                end
            end
        endcase
    end

    // A loss coinciding with a clear still leaves one loss on record.
    always_comb begin
        w_lock_lost_nxt  = r_lock_lost;
        w_loss_count_nxt = r_loss_count;
        if (w_loss) begin
            w_lock_lost_nxt  = 1'b1;
            w_loss_count_nxt = clear_flags ? CNT_W'(1) : sat_inc(r_loss_count);
        end else if (clear_flags) begin
            w_lock_lost_nxt  = 1'b0;
            w_loss_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= WAIT_LOCK;
            r_stab_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_core_reset  <= 1'b1;
            r_audio_reset <= 1'b1;
            r_ready       <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_loss_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_stab_cnt    <= w_stab_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_core_reset  <= w_core_reset_nxt;
            r_audio_reset <= w_audio_reset_nxt;
            r_ready       <= w_ready_nxt;
            r_lock_lost   <= w_lock_lost_nxt;
            r_loss_count  <= w_loss_count_nxt;
        end
    end

    assign core_reset  = r_core_reset;
    assign audio_reset = r_audio_reset;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;
    assign loss_count  = r_loss_count;
    assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: run-length model of the lock sequence checked every
// half cycle, plus literal expectations at the edges that matter.
module tb_pll_reset_sequencer;

    localparam int S    = 1024;
    localparam int G    = 16;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk;
    logic          reset;
    logic          pll_lock;
    logic          clear_flags;
    logic          core_reset;
    logic          audio_reset;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] loss_count;
    logic [1:0]    state;

    pll_reset_sequencer #(
        .STABLE_CYCLES(S),
        .RELEASE_GAP  (G),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .clear_flags(clear_flags),
        .core_reset (core_reset),
        .audio_reset(audio_reset),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the whole sequence is a function of how many consecutive edges the
    // synchronised lock has been seen high.
    int m_run;
    bit m_s1;
    bit m_s2;
    bit m_lost;
    int m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run  <= 0;
            m_s1   <= 1'b0;
            m_s2   <= 1'b0;
            m_lost <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (!m_s2 && m_run >= S) begin
                m_lost <= 1'b1;
                m_cnt  <= clear_flags ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
            end else if (clear_flags) begin
                m_lost <= 1'b0;
                m_cnt  <= 0;
            end
            m_run <= m_s2 ? ((m_run < S + G) ? m_run + 1 : m_run) : 0;
            m_s2  <= m_s1;
            m_s1  <= pll_lock;
        end
    end

    int    n_vec;
    int    n_fail;
    int    lit_seq;
    int    lit_done;
    string lit_name;
    bit    lit_core, lit_audio, lit_ready, lit_lost;
    int    lit_cnt, lit_state;
    bit    e_core, e_audio, e_ready;
    int    e_state;

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        lit_done = 0;
    end

    always begin
        @(negedge clk or posedge reset);
        #1;
        e_core  = (m_run < S);
        e_audio = (m_run < S + G);
        e_ready = (m_run >= S + G);
        e_state = (m_run == 0) ? 0 : (m_run < S) ? 1 : (m_run < S + G) ? 2 : 3;
        n_vec++;
        if (core_reset !== e_core || audio_reset !== e_audio || ready !== e_ready ||
            lock_lost !== m_lost || int'(loss_count) != m_cnt || int'(state) != e_state) begin
            n_fail++;
            $display("FAIL model t=%0t got c/a/r/l=%b%b%b%b cnt=%0d st=%0d expected %b%b%b%b cnt=%0d st=%0d",
                     $time, core_reset, audio_reset, ready, lock_lost, loss_count, state,
                     e_core, e_audio, e_ready, m_lost, m_cnt, e_state);
        end
        n_vec++;
        if ((!audio_reset && core_reset) || (ready !== (state == 2'd3))) begin
            n_fail++;
            $display("FAIL invariant t=%0t got c/a/r=%b%b%b st=%0d", $time,
                     core_reset, audio_reset, ready, state);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            n_vec++;
            if (core_reset !== lit_core || audio_reset !== lit_audio || ready !== lit_ready ||
                lock_lost !== lit_lost || int'(loss_count) != lit_cnt || int'(state) != lit_state) begin
                n_fail++;
                $display("FAIL %s t=%0t got c/a/r/l=%b%b%b%b cnt=%0d st=%0d expected %b%b%b%b cnt=%0d st=%0d",
                         lit_name, $time, core_reset, audio_reset, ready, lock_lost, loss_count, state,
                         lit_core, lit_audio, lit_ready, lit_lost, lit_cnt, lit_state);
            end
        end
    end

    task automatic post_lit(input string name, input bit c, input bit a, input bit r,
                            input bit l, input int cnt, input int st);
        lit_name  = name;
        lit_core  = c;
        lit_audio = a;
        lit_ready = r;
        lit_lost  = l;
        lit_cnt   = cnt;
        lit_state = st;
        lit_seq++;
    endtask

    // Called just after a falling edge; checks the outputs after the n-th rising edge.
    task automatic expect_after(input int n, input string name, input bit c, input bit a,
                                input bit r, input bit l, input int cnt, input int st);
        repeat (n - 1) @(negedge clk);
        @(posedge clk);
        #1;
        post_lit(name, c, a, r, l, cnt, st);
        @(negedge clk);
    endtask

    task automatic powerup(input bit l, input int cnt);
        pll_lock = 1'b1;
        expect_after(1025, "pre_core_release", 1, 1, 0, l, cnt, 1);
        expect_after(1,    "core_release",     0, 1, 0, l, cnt, 2);
        expect_after(15,   "gap_hold",         0, 1, 0, l, cnt, 2);
        expect_after(1,    "audio_release",    0, 0, 1, l, cnt, 3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        lit_seq     = 0;
        reset       = 1'b1;
        pll_lock    = 1'b0;
        clear_flags = 1'b0;
        @(negedge clk);
        expect_after(1, "reset_state", 1, 1, 0, 0, 0, 0);
        reset = 1'b0;

        // Glitch at stability count 500: three low cycles restart the window.
        pll_lock = 1'b1;
        expect_after(502, "stabilize_500", 1, 1, 0, 0, 0, 1);
        pll_lock = 1'b0;
        expect_after(2, "glitch_sync", 1, 1, 0, 0, 0, 1);
        expect_after(1, "glitch_abort", 1, 1, 0, 0, 0, 0);
        powerup(1'b0, 0);

        // Loss in RUN, then full re-lock.
        pll_lock = 1'b0;
        expect_after(2, "run_hold", 0, 0, 1, 0, 0, 3);
        expect_after(1, "run_loss", 1, 1, 0, 1, 1, 0);
        expect_after(4, "idle_after_loss", 1, 1, 0, 1, 1, 0);
        powerup(1'b1, 1);

        clear_flags = 1'b1;
        expect_after(1, "clear_in_run", 0, 0, 1, 0, 0, 3);
        clear_flags = 1'b0;

        // Loss during RELEASE at gap count 5.
        pll_lock = 1'b0;
        expect_after(2, "run_hold2", 0, 0, 1, 0, 0, 3);
        expect_after(1, "run_loss2", 1, 1, 0, 1, 1, 0);
        expect_after(3, "idle2", 1, 1, 0, 1, 1, 0);
        pll_lock = 1'b1;
        expect_after(1029, "in_release", 0, 1, 0, 1, 1, 2);
        pll_lock = 1'b0;
        expect_after(2, "release_hold", 0, 1, 0, 1, 1, 2);
        expect_after(1, "release_loss", 1, 1, 0, 1, 2, 0);

        clear_flags = 1'b1;
        expect_after(1, "clear_idle", 1, 1, 0, 0, 0, 0);
        clear_flags = 1'b0;

        // Five losses saturate the 2-bit counter at 3.
        for (int i = 1; i <= 5; i++) begin
            powerup(i > 1, (i - 1 < CMAX) ? i - 1 : CMAX);
            pll_lock = 1'b0;
            expect_after(2, "sat_hold", 0, 0, 1, 1'(i > 1), (i - 1 < CMAX) ? i - 1 : CMAX, 3);
            expect_after(1, "sat_loss", 1, 1, 0, 1, (i < CMAX) ? i : CMAX, 0);
        end

        // Clear on the same edge as a loss: the loss wins.
        powerup(1'b1, 3);
        pll_lock = 1'b0;
        expect_after(2, "coinc_hold", 0, 0, 1, 1, 3, 3);
        clear_flags = 1'b1;
        expect_after(1, "coinc_loss", 1, 1, 0, 1, 1, 0);
        clear_flags = 1'b0;

        // Asynchronous reset between edges while in RUN.
        powerup(1'b1, 1);
        #2;
        post_lit("async_reset", 1, 1, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        powerup(1'b0, 0);
        expect_after(5, "final_run", 0, 0, 1, 0, 0, 3);

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
